// File: rtl/mc_core_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, function codes,
// controller state encoding, ALU select, control word and small helpers.
// Optional jump support is selected with the macro MC_CORE_JUMP_EN.
package mc_core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, WB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_ctl_t;

    // Datapath enables produced by the controller each cycle.
    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     addr_pc;      // memory address comes from PC (fetch) not ALUOut
        logic     ir_we;
        logic     pc_inc;
        logic     ab_we;
        logic     alu_out_we;
        logic     alu_src_imm;
        alu_ctl_t alu_op;
        logic     rf_we;
        logic     rf_dst_rd;    // 1: write rd, 0: write rt
        logic     rf_from_mdr;  // 1: write MDR, 0: write ALUOut
        logic     mdr_we;
        logic     branch;       // take branch target when A==B
        logic     jump;
        logic     cnt_inc;
        logic     halt;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic alu_ctl_t funct_to_alu(input logic [5:0] f);
        alu_ctl_t op;
        case (f)
            FN_SUB:  op = SUB;
            FN_AND:  op = AND;
            FN_OR:   op = OR;
            FN_SLT:  op = SLT;
            default: op = ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_calc(input alu_ctl_t op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            SUB:     r = a - b;
            AND:     r = a & b;
            OR:      r = a | b;
            SLT:     r = {31'b0, ($signed(a) < $signed(b))};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_mips_core_if.sv
// Unified instruction/data memory bus with a req/ack handshake.
// The core drives the master side; the memory (or a model) the slave side.
interface multicycle_mips_core_if #(
    parameter int ADDR_W = 8
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mc_core_ctrl.sv
// Controller FSM for the multicycle MIPS core. Sequences fetch, decode,
// execute, memory and writeback and emits the datapath control word.
// The JUMP state is only reachable when MC_CORE_JUMP_EN is defined.
module mc_core_ctrl
    import mc_core_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ack_i,
    output ctrl_t      ctrl_o
);

    state_t state_q, state_d;
    logic   run_q;   // low for one cycle after reset so the first fetch waits for clr to fall

    // State register; reset parks the FSM in FETCH with requests held off.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ADD;
        state_d       = state_q;
        case (state_q)
            FETCH: begin
                ctrl_o.mem_req = run_q;
                ctrl_o.addr_pc = 1'b1;
                if (run_q && mem_ack_i) begin
                    ctrl_o.ir_we  = 1'b1;
                    ctrl_o.pc_inc = 1'b1;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                ctrl_o.ab_we = 1'b1;
                case (opcode_i)
                    OP_RTYPE:     state_d = funct_legal(funct_i) ? EXEC : HALT;
                    OP_ADDI:      state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MC_CORE_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      state_d = HALT;
                endcase
            end
            EXEC: begin
                ctrl_o.alu_out_we  = 1'b1;
                ctrl_o.alu_src_imm = (opcode_i != OP_RTYPE);
                ctrl_o.alu_op      = (opcode_i == OP_RTYPE) ? funct_to_alu(funct_i) : ADD;
                state_d            = WB;
            end
            WB: begin
                ctrl_o.rf_we     = 1'b1;
                ctrl_o.rf_dst_rd = (opcode_i == OP_RTYPE);
                ctrl_o.cnt_inc   = 1'b1;
                state_d          = FETCH;
            end
            MEMADR: begin
                ctrl_o.alu_out_we  = 1'b1;
                ctrl_o.alu_src_imm = 1'b1;
                state_d            = (opcode_i == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                if (mem_ack_i) begin
                    ctrl_o.mdr_we = 1'b1;
                    state_d       = MEMWB;
                end
            end
            MEMWB: begin
                ctrl_o.rf_we       = 1'b1;
                ctrl_o.rf_from_mdr = 1'b1;
                ctrl_o.cnt_inc     = 1'b1;
                state_d            = FETCH;
            end
            MEMWR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_we  = 1'b1;
                if (mem_ack_i) begin
                    ctrl_o.cnt_inc = 1'b1;
                    state_d        = FETCH;
                end
            end
            BRANCH: begin
                ctrl_o.branch  = 1'b1;
                ctrl_o.cnt_inc = 1'b1;
                state_d        = FETCH;
            end
`ifdef MC_CORE_JUMP_EN
            JUMP: begin
                ctrl_o.jump    = 1'b1;
                ctrl_o.cnt_inc = 1'b1;
                state_d        = FETCH;
            end
`endif
            HALT: begin
                ctrl_o.halt = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS core top: PC, IR, A/B, ALUOut, MDR, register file, ALU
// and the retired-instruction counter; sequencing lives in mc_core_ctrl.
// Jump support is enabled by defining MC_CORE_JUMP_EN.
module multicycle_mips_core
    import mc_core_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        clr,
    multicycle_mips_core_if.master      mem,
    output logic                        halt,
    output logic [ADDR_W-1:0]           pc,
    output logic [CNT_W-1:0]            instr_count
);

    ctrl_t             ctrl;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q, a_q, b_q, alu_out_q, mdr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       regs_q [32];

    logic [4:0]        rs, rt, rd, waddr;
    logic [15:0]       imm16;
    logic [31:0]       sext_imm, br_off, rd1, rd2, alu_b, alu_res, wdata;
    logic [31:0]       wr_sel;
    logic [ADDR_W-1:0] addr_raw;

    mc_core_ctrl u_ctrl (
        .clk       (clk),
        .clr       (clr),
        .opcode_i  (ir_q[31:26]),
        .funct_i   (ir_q[5:0]),
        .mem_ack_i (mem.ack),
        .ctrl_o    (ctrl)
    );

    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign imm16    = ir_q[15:0];
    assign sext_imm = sext16(imm16);
    assign br_off   = {sext_imm[29:0], 2'b00};

    // $0 is hardwired to zero on the read side, so a same-cycle write to $0 is invisible.
    assign rd1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rd2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];

    assign alu_b   = ctrl.alu_src_imm ? sext_imm : b_q;
    assign alu_res = alu_calc(ctrl.alu_op, a_q, alu_b);

    assign waddr = ctrl.rf_dst_rd ? rd : rt;
    assign wdata = ctrl.rf_from_mdr ? mdr_q : alu_out_q;

    // One write-select per register; entry 0 never enables.
    for (genvar gi = 0; gi < 32; gi++) begin : g_wsel
        if (gi == 0) begin : g_zero
            assign wr_sel[gi] = 1'b0;
        end else begin : g_reg
            assign wr_sel[gi] = ctrl.rf_we && (waddr == 5'(gi));
        end
    end

    // Register file write port; reset clears every entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (clr) begin
                regs_q[i] <= '0;
            end else if (wr_sel[i]) begin
                regs_q[i] <= wdata;
            end
        end
    end

    // Architectural and inter-state datapath registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (ctrl.ir_we) begin
                ir_q <= mem.rdata;
            end
            if (ctrl.pc_inc) begin
                pc_q <= pc_q + ADDR_W'(4);
            end else if (ctrl.branch && (a_q == b_q)) begin
                pc_q <= pc_q + ADDR_W'(br_off);
            end else if (ctrl.jump) begin
                pc_q <= ADDR_W'({ir_q[25:0], 2'b00});
            end
            if (ctrl.ab_we) begin
                a_q <= rd1;
                b_q <= rd2;
            end
            if (ctrl.alu_out_we) begin
                alu_out_q <= alu_res;
            end
            if (ctrl.mdr_we) begin
                mdr_q <= mem.rdata;
            end
            if (ctrl.cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Bus outputs read as zero whenever no request is active.
    assign addr_raw  = ctrl.addr_pc ? pc_q : alu_out_q[ADDR_W-1:0];
    assign mem.req   = ctrl.mem_req;
    assign mem.we    = ctrl.mem_req & ctrl.mem_we;
    assign mem.addr  = ctrl.mem_req ? (addr_raw & ~ADDR_W'(3)) : '0;
    assign mem.wdata = (ctrl.mem_req && ctrl.mem_we) ? b_q : '0;

    assign halt        = ctrl.halt;
    assign pc          = pc_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Bench for multicycle_mips_core: memory model with programmable wait states,
// a write scoreboard fed by the stimulus and drained by a monitor, plus
// directed checks of PC, counter, halt and reset behaviour.
`timescale 1ns/1ps
module tb_multicycle_mips_core;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  instr_count;

    always #5 clk = ~clk;

    multicycle_mips_core_if #(.ADDR_W(ADDR_W)) mem_bus ();

    multicycle_mips_core #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .mem         (mem_bus),
        .halt        (halt),
        .pc          (pc),
        .instr_count (instr_count)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem_q [64];
    int unsigned wait_n  = 0;
    int unsigned wcnt_q  = 0;
    logic        ld_en   = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    assign mem_bus.ack   = mem_bus.req && (wcnt_q == wait_n);
    assign mem_bus.rdata = mem_q[mem_bus.addr[7:2]];

    always @(posedge clk) begin
        if (mem_bus.req && !mem_bus.ack) wcnt_q <= wcnt_q + 1;
        else                             wcnt_q <= 0;
        if (ld_en) mem_q[ld_addr] <= ld_data;
        else if (mem_bus.req && mem_bus.we && mem_bus.ack)
            mem_q[mem_bus.addr[7:2]] <= mem_bus.wdata;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_wr[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    // Monitor: compares each completed write against the queue and checks
    // that a pending request holds its address/direction/data until ack.
    task automatic monitor();
        logic        p_req = 1'b0;
        logic        p_ack = 1'b0;
        logic        p_we  = 1'b0;
        logic [7:0]  p_addr = '0;
        logic [31:0] p_wd   = '0;
        wr_t         w;
        forever begin
            @(negedge clk);
            if (!clr && mem_bus.req && p_req && !p_ack) begin
                check("hold_addr",  {24'h0, mem_bus.addr}, {24'h0, p_addr});
                check("hold_we",    {31'h0, mem_bus.we},   {31'h0, p_we});
                check("hold_wdata", mem_bus.wdata,          p_wd);
            end
            if (!clr && mem_bus.req && mem_bus.we && mem_bus.ack) begin
                if (exp_wr.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr=0x%02h data=0x%08h required none",
                             mem_bus.addr, mem_bus.wdata);
                end else begin
                    w = exp_wr.pop_front();
                    $display("write addr=0x%02h data=0x%08h (expect 0x%02h 0x%08h)",
                             mem_bus.addr, mem_bus.wdata, w.addr, w.data);
                    check("wr_addr", {24'h0, mem_bus.addr}, {24'h0, w.addr});
                    check("wr_data", mem_bus.wdata, w.data);
                end
            end
            p_req  = mem_bus.req;
            p_ack  = mem_bus.ack;
            p_we   = mem_bus.we;
            p_addr = mem_bus.addr;
            p_wd   = mem_bus.wdata;
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic mem_write(input int idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = 6'(idx);
        ld_data = d;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    task automatic load_prog(input logic [31:0] prog[$]);
        for (int i = 0; i < 64; i++) mem_write(i, (i < prog.size()) ? prog[i] : 32'h0);
    endtask

    task automatic wait_pc(input logic [7:0] v, input int lim, input string name, output int edges);
        edges = 0;
        while (pc !== v && edges < lim) begin
            @(posedge clk); #1;
            edges++;
        end
        check(name, {24'h0, pc}, {24'h0, v});
    endtask

    task automatic wait_cnt(input logic [15:0] v, input int lim, input string name, output int edges);
        edges = 0;
        while (instr_count !== v && edges < lim) begin
            @(posedge clk); #1;
            edges++;
        end
        check(name, {16'h0, instr_count}, {16'h0, v});
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] prog[$];
        int          e;
        logic [15:0] c0;

        fork monitor(); join_none

        // Reset state
        step(2);
        check("rst_req",   {31'h0, mem_bus.req}, 32'h0);
        check("rst_addr",  {24'h0, mem_bus.addr}, 32'h0);
        check("rst_wdata", mem_bus.wdata, 32'h0);
        check("rst_halt",  {31'h0, halt}, 32'h0);
        check("rst_pc",    {24'h0, pc}, 32'h0);
        check("rst_cnt",   {16'h0, instr_count}, 32'h0);

        // Test 1: ALU ops, $0 write, lw, beq taken loop, zero wait states
        $display("test1 alu/beq zero-wait");
        wait_n = 0;
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 1, 16'd5));        // 00 addi $1,$0,5
        prog.push_back(enc_i(6'h08, 0, 2, 16'd7));        // 04 addi $2,$0,7
        prog.push_back(enc_r(1, 2, 3, 6'h20));            // 08 add $3,$1,$2
        prog.push_back(enc_i(6'h2B, 0, 3, 16'h0080));     // 0C sw $3,0x80
        prog.push_back(enc_r(1, 2, 0, 6'h20));            // 10 add $0,$1,$2
        prog.push_back(enc_i(6'h2B, 0, 0, 16'h0084));     // 14 sw $0,0x84
        prog.push_back(enc_r(1, 2, 5, 6'h22));            // 18 sub $5,$1,$2
        prog.push_back(enc_r(5, 1, 6, 6'h2A));            // 1C slt $6,$5,$1
        prog.push_back(enc_r(1, 5, 7, 6'h2A));            // 20 slt $7,$1,$5
        prog.push_back(enc_r(1, 2, 8, 6'h24));            // 24 and $8,$1,$2
        prog.push_back(enc_r(1, 2, 9, 6'h25));            // 28 or $9,$1,$2
        prog.push_back(enc_i(6'h08, 0, 10, 16'hFFFF));    // 2C addi $10,$0,-1
        prog.push_back(enc_i(6'h08, 10, 11, 16'd2));      // 30 addi $11,$10,2
        prog.push_back(enc_i(6'h2B, 0, 5, 16'h0088));     // 34 sw $5
        prog.push_back(enc_i(6'h2B, 0, 6, 16'h008C));     // 38 sw $6
        prog.push_back(enc_i(6'h2B, 0, 7, 16'h0090));     // 3C sw $7
        prog.push_back(enc_i(6'h2B, 0, 8, 16'h0094));     // 40 sw $8
        prog.push_back(enc_i(6'h2B, 0, 9, 16'h0098));     // 44 sw $9
        prog.push_back(enc_i(6'h2B, 0, 11, 16'h009C));    // 48 sw $11
        prog.push_back(enc_i(6'h23, 0, 12, 16'h0080));    // 4C lw $12,0x80
        prog.push_back(enc_i(6'h2B, 0, 12, 16'h00A0));    // 50 sw $12,0xA0
        prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));     // 54 beq $0,$0,-1
        load_prog(prog);
        push_wr(8'h80, 32'd12);
        push_wr(8'h84, 32'd0);
        push_wr(8'h88, 32'hFFFFFFFE);
        push_wr(8'h8C, 32'd1);
        push_wr(8'h90, 32'd0);
        push_wr(8'h94, 32'd5);
        push_wr(8'h98, 32'd7);
        push_wr(8'h9C, 32'd1);
        push_wr(8'hA0, 32'd12);
        clr = 1'b0;
        step(12);
        check("t1_cnt_at12", {16'h0, instr_count}, 32'd2);
        step(1);
        check("t1_cnt_at13", {16'h0, instr_count}, 32'd3);
        check("t1_pc_at13",  {24'h0, pc}, 32'h0C);
        check("t1_fetch_addr", {24'h0, mem_bus.addr}, 32'h0C);
        wait_pc(8'h58, 400, "t1_reach_beq", e);
        check("t1_drained", exp_wr.size(), 32'd0);
        c0 = instr_count;
        step(2);
        check("t1_beq_taken_pc", {24'h0, pc}, 32'h54);
        check("t1_beq_cnt", {16'h0, instr_count}, {16'h0, c0 + 16'd1});
        step(1);
        check("t1_beq_loop_pc", {24'h0, pc}, 32'h58);

        // Test 2: sw/lw with two wait states per access
        $display("test2 sw/lw two-wait");
        clr = 1'b1;
        wait_n = 2;
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 3, 16'd12));       // 00 addi $3,$0,12
        prog.push_back(enc_i(6'h2B, 0, 3, 16'h0080));     // 04 sw $3,0x80
        prog.push_back(enc_i(6'h23, 0, 4, 16'h0080));     // 08 lw $4,0x80
        prog.push_back(enc_i(6'h2B, 0, 4, 16'h0084));     // 0C sw $4,0x84
        prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));     // 10 beq loop
        load_prog(prog);
        push_wr(8'h80, 32'd12);
        push_wr(8'h84, 32'd12);
        clr = 1'b0;
        wait_cnt(16'd1, 50, "t2_addi_done", e);
        check("t2_addi_edges", e, 32'd7);
        wait_cnt(16'd2, 50, "t2_sw_done", e);
        check("t2_sw_cycles", e, 32'd8);
        wait_pc(8'h14, 100, "t2_reach_beq", e);
        check("t2_drained", exp_wr.size(), 32'd0);

        // Test 3: beq not taken
        $display("test3 beq not taken");
        clr = 1'b1;
        wait_n = 0;
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 1, 16'd1));        // 00 addi $1,$0,1
        prog.push_back(enc_i(6'h04, 1, 0, 16'd5));        // 04 beq $1,$0,+5 (not taken)
        prog.push_back(enc_i(6'h2B, 0, 1, 16'h0080));     // 08 sw $1,0x80
        prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));     // 0C beq loop
        load_prog(prog);
        push_wr(8'h80, 32'd1);
        clr = 1'b0;
        wait_cnt(16'd1, 50, "t3_addi_done", e);
        wait_cnt(16'd2, 50, "t3_beq_done", e);
        check("t3_beq_cycles", e, 32'd3);
        check("t3_pc_fallthru", {24'h0, pc}, 32'h08);
        wait_pc(8'h10, 50, "t3_reach_loop", e);
        check("t3_drained", exp_wr.size(), 32'd0);

        // Test 4: illegal opcode halt, then reset recovery
        $display("test4 illegal opcode");
        clr = 1'b1;
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 1, 16'd1));        // 00 addi $1,$0,1
        prog.push_back(32'hFC000000);                     // 04 opcode 3F
        load_prog(prog);
        clr = 1'b0;
        wait_pc(8'h08, 50, "t4_reach_illegal", e);
        check("t4_halt_in_decode", {31'h0, halt}, 32'h0);
        step(1);
        check("t4_halt", {31'h0, halt}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            check("t4_no_req", {31'h0, mem_bus.req}, 32'h0);
            step(1);
        end
        check("t4_cnt", {16'h0, instr_count}, 32'd1);
        check("t4_halt_held", {31'h0, halt}, 32'h1);
        clr = 1'b1;
        step(1);
        check("t4_clr_halt", {31'h0, halt}, 32'h0);
        check("t4_clr_pc",   {24'h0, pc}, 32'h0);
        check("t4_clr_cnt",  {16'h0, instr_count}, 32'h0);

        // Test 5: reset during a store wait
        $display("test5 clr during store wait");
        wait_n = 4;
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 1, 16'd9));        // 00 addi $1,$0,9
        prog.push_back(enc_i(6'h2B, 0, 1, 16'h0080));     // 04 sw $1,0x80
        prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));     // 08 beq loop
        load_prog(prog);
        mem_write(32, 32'hDEADBEEF);
        clr = 1'b0;
        e = 0;
        while (!(mem_bus.req && mem_bus.we) && e < 60) begin step(1); e++; end
        check("t5_store_seen", {31'h0, mem_bus.req && mem_bus.we}, 32'h1);
        step(1);
        clr = 1'b1;
        step(1);
        check("t5_req_dropped", {31'h0, mem_bus.req}, 32'h0);
        check("t5_pc_reset",    {24'h0, pc}, 32'h0);
        step(6);
        check("t5_mem_intact", mem_q[32], 32'hDEADBEEF);

        // Test 6: jump (or halt when jumps are not built in)
        $display("test6 jump opcode");
        wait_n = 0;
        prog = {};
        prog.push_back({6'h02, 26'h0000010});             // 00 j 0x10 -> 0x40
        for (int i = 1; i < 16; i++) prog.push_back(32'h0);
        prog.push_back(enc_i(6'h08, 0, 2, 16'd3));        // 40 addi $2,$0,3
        prog.push_back(enc_i(6'h2B, 0, 2, 16'h0080));     // 44 sw $2,0x80
        prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));     // 48 beq loop
        load_prog(prog);
`ifdef MC_CORE_JUMP_EN
        push_wr(8'h80, 32'd3);
`endif
        clr = 1'b0;
        e = 0;
        while (pc !== 8'h40 && halt !== 1'b1 && e < 30) begin step(1); e++; end
`ifdef MC_CORE_JUMP_EN
        check("t6_jump_pc",  {24'h0, pc}, 32'h40);
        check("t6_jump_cnt", {16'h0, instr_count}, 32'd1);
        check("t6_jump_nohalt", {31'h0, halt}, 32'h0);
        wait_pc(8'h4C, 50, "t6_reach_loop", e);
`else
        check("t6_halt",     {31'h0, halt}, 32'h1);
        check("t6_halt_cnt", {16'h0, instr_count}, 32'd0);
        check("t6_halt_pc",  {24'h0, pc}, 32'h04);
`endif
        check("t6_drained", exp_wr.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_mips_core.md
Name: multicycle_mips_core

Overview:
Multicycle successor to the single-cycle MIPS processor. It is parametrised in address width and reset vector, and talks to one unified instruction/data memory over a req/ack handshake that tolerates wait states. A controller FSM sequences fetch, decode, execute, memory and writeback, so each instruction takes 3-5 cycles plus memory waits. The core also provides illegal-opcode halt and a retired-instruction counter.

Parameters:
ADDR_W, 8, byte-address width of PC and mem_addr (legal range 4..28).
PC_RESET, 0, PC value loaded on reset (ADDR_W bits, word aligned).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state updates on rising edge.
clr  input  1  reset, synchronous, active-high.
mem_req  output  1  memory access request.
mem_we  output  1  1 = write, 0 = read; valid while mem_req.
mem_addr  output  ADDR_W  byte address; bits [1:0] always 0.
mem_wdata  output  32  store data; valid while mem_req && mem_we.
mem_rdata  input  32  read data; sampled on the edge where mem_ack=1.
mem_ack  input  1  access complete; may be asserted in the same cycle as mem_req.
halt  output  1  core stopped on an illegal opcode.
pc  output  ADDR_W  current PC.
instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- Reset: clr sampled high forces the following, overriding any in-flight access:
  - state=FETCH, pc=PC_RESET, all 32 GPRs=0, IR=0, instr_count=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halt=0.
  - The first fetch is requested in the cycle after clr falls.
- Register file:
  - 32x32 registers; $0 reads 0 and ignores writes.
  - Two asynchronous reads, one synchronous write.
- Instruction set (opcode/funct in hex):
  - R-type 00 with funct add 20, sub 22, and 24, or 25, slt 2A.
  - lw 23, sw 2B, beq 04, addi 08, j 02 (j is optional, see Optional Feature).
  - Any other opcode, or an unlisted funct with opcode 00, is illegal.
- Arithmetic:
  - add/sub/addi wrap modulo 2^32; no overflow trap.
  - slt is a signed compare.
  - Immediates are sign-extended.
  - Branch target = (PC+4) + (sext(imm16)<<2), truncated to ADDR_W.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, addr=pc. On mem_ack: IR<=mem_rdata, pc<=pc+4 (wraps modulo 2^ADDR_W) -> DECODE.
  - DECODE: latch A=rs and B=rt. Branch by opcode: R-type/addi -> EXEC; lw/sw -> MEMADR; beq -> BRANCH; j -> JUMP; illegal -> HALT.
  - EXEC: ALUOut<=A op (B or sext imm) -> WB.
  - WB: write rd (R-type) or rt (addi) -> FETCH.
  - MEMADR: ALUOut<=A+sext(imm). lw -> MEMRD; sw -> MEMWR.
  - MEMRD: read ALUOut until ack, latch MDR -> MEMWB.
  - MEMWB: rt<=MDR -> FETCH.
  - MEMWR: write B to ALUOut until ack -> FETCH.
  - BRANCH: if A==B, pc<=target -> FETCH.
  - JUMP: pc<={imm26,2'b00}[ADDR_W-1:0] -> FETCH.
  - HALT: halt=1, no memory requests, remains until clr. instr_count does not count the illegal instruction.
- Latency with zero wait states: R-type/addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each wait cycle adds 1.
- Handshake:
  - While mem_req=1, addr/we/wdata hold stable until mem_ack.
  - mem_ack with mem_req=0 is ignored.
  - mem_req drops in the cycle after ack.
- instr_count increments by 1 on entry to FETCH from WB, MEMWB, MEMWR, BRANCH or JUMP, and wraps at 2^CNT_W.
- A write to $0 and a read of the same register in the same cycle return 0.

Optional Feature:
Macro MC_CORE_JUMP_EN.
- Defined: opcode 02 executes as j via the JUMP state.
- Undefined: the JUMP state is absent, and opcode 02 is illegal and goes to HALT.

Decomposition:
- Package mc_core_pkg holds:
  - opcode and funct localparams;
  - state_t enum (FETCH, DECODE, EXEC, WB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, HALT);
  - alu_ctl_t enum (ADD, SUB, AND, OR, SLT).
- Sub-module mc_core_ctrl contains the FSM and produces datapath enables and ALU select from opcode/funct/mem_ack.
- Datapath, register file and ALU live in the top module.

Test Plan:
- Zero-wait memory holding addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12, instr_count=3 after 12 cycles, pc=0x0C.
- sw $3,0x20($0) then lw $4,0x20($0), with a memory model inserting 2 wait cycles per access -> write at addr 0x20 with data 12, $4=12. mem_req/addr held stable across the waits; sw takes 4+2+2 cycles.
- beq taken ($1==$1, imm=-1) -> pc returns to the beq address, loops; beq not taken -> pc+4; each takes 3 cycles.
- Opcode 3F fetched -> halt=1 in the cycle after DECODE, mem_req stays 0 for 20 cycles, instr_count unchanged. Asserting clr clears halt and pc=PC_RESET.
- clr asserted during the MEMWR wait -> next cycle mem_req=0 and state=FETCH; no write is issued; the target memory location is unchanged.
- add $0,$1,$2 -> $0 still reads 0. With MC_CORE_JUMP_EN, j 0x10 -> pc=0x40 (ADDR_W=8). Without the macro, the same opcode sets halt=1.
